lcd_in_scaler: RTL
==================

// Module: lcd_in_scaler
// PURPOSE
//  Downscaling/format stage between the LCD input capture (lcd_pclk_i domain) and the SDRAM write FIFO.
//  Samples the incoming RGB888 DE/VS stream and decimates it to OUT_H x OUT_V with a nearest-neighbour DDA.
//  Converts each kept pixel to RGB565 and emits one FIFO write per kept pixel, plus a FIFO clear at frame start.
// PARAMETERS
//  IN_H    800  active input pixels per line (1..2047)
//  IN_V    480  active input lines per frame (1..2047)
//  OUT_H   400  output pixels per line, 1 <= OUT_H <= IN_H
//  OUT_V   240  output lines per frame, 1 <= OUT_V <= IN_V
//  VS_POL  1    input VS active level (1 = active-high)
// PORTS
//  clk         in   1   input pixel clock (lcd_pclk_i)
//  rst         in   1   asynchronous reset, active-high
//  lcd_de_i    in   1   input data enable
//  lcd_vs_i    in   1   input vertical sync, polarity VS_POL
//  lcd_rgb_i   in   24  input pixel {R8,G8,B8}
//  fifo_clr    out  1   one-cycle pulse at frame start
//  wr_req      out  1   one-cycle pulse per output pixel
//  wr_data     out  16  RGB565 {R5,G6,B5}, valid while wr_req=1
//  out_x       out  11  x index of current wr_data (0..OUT_H-1)
//  out_y       out  11  y index of current wr_data (0..OUT_V-1)
//  frame_done  out  1   one-cycle pulse with the write of pixel (OUT_H-1, OUT_V-1)
//  line_short  out  1   sticky: some kept line delivered < OUT_H pixels; cleared at frame start
// BEHAVIOUR
//  - Reset: every output 0; accumulators, counters, input registers 0.
//  - Stage 0 registers de/vs/rgb. Frame start = registered VS edge into its active level.
//  - Frame start: fifo_clr=1 for 1 cycle; vacc, y_in, out_y, line_short cleared; any line in progress aborted.
//  - Line start = rising edge of registered DE. Vertical DDA: vsum = vacc + OUT_V; keep line iff
//    vsum >= IN_V and kept-line count < OUT_V; vacc <= keep ? vsum-IN_V : vsum. hacc and out_x cleared.
//  - Per DE pixel in a kept line: hsum = hacc + OUT_H; keep pixel iff hsum >= IN_H and out_x < OUT_H;
//    hacc <= keep ? hsum-IN_H : hsum. Pixels beyond OUT_H are dropped, never wrapped.
//  - Accumulators 12 bit unsigned, always < IN_H / IN_V; no overflow for legal parameters.
//  - Latency: wr_req/wr_data appear 2 clk after the pixel is present on lcd_rgb_i; throughput 1 pixel/clk.
//  - out_x/out_y are index of the pixel being written; out_x increments after each write; out_y
//    increments at the DE falling edge of a kept line.
//  - DE falling edge of a kept line with out_x < OUT_H: set line_short; no padding pixels generated.
//  - Lines/pixels after OUT_V kept lines, or DE while VS active: ignored, no wr_req.
//  - VS edge coinciding with DE: frame start wins; that pixel is dropped.
//  - OUT_H=IN_H and OUT_V=IN_V: every pixel passes (pure format conversion).
//  - Async reset mid-line: outputs 0 immediately; processing resumes at next frame start only
//    (DE before first frame start after reset is ignored).
// CONFIGURATION
//  LCD_SCALE_ROUND_EN defined: R5=min(31,(R8+4)>>3), G6=min(63,(G8+2)>>2), B5=min(31,(B8+4)>>3).
//  Not defined: truncation, R5=R8[7:3], G6=G8[7:2], B5=B8[7:3]. Latency unchanged either way.
// TESTING
//  1 Defaults, one 800x480 frame, rgb=x-ramp -> 240 lines x 400 wr_req; kept input x=1,3,..,799,
//    y=1,3,..,479; frame_done once at (399,239); line_short=0.
//  2 IN=OUT=8x4 -> 32 writes, out_x 0..7 per line, wr_data=RGB565 of each input, 2-clk latency.
//  3 Pixel 24'h0C0606: without ROUND -> 16'h0820; with LCD_SCALE_ROUND_EN -> 16'h1041;
//    24'hFFFFFF -> 16'hFFFF in both builds.
//  4 Kept line with only 300 DE pixels (defaults) -> 150 writes on that line, line_short=1 until next frame start.
//  5 VS asserted mid-line -> fifo_clr pulse, wr_req stops; next frame restarts at out_x=0, out_y=0.
//  6 rst pulsed mid-line -> all outputs 0 same cycle; DE before next VS ignored; next frame output correct.

Source files
------------

// File: rtl/lcd_in_scaler.sv
// Purpose: decimates an RGB888 DE/VS LCD stream to OUT_H x OUT_V (nearest-neighbour DDA) and emits RGB565 FIFO writes.
// Latency: wr_req/wr_data are valid 2 clk after the pixel is on lcd_rgb_i; throughput 1 pixel/clk.
// Backpressure: none; the LCD source cannot stall. Optional macro LCD_SCALE_ROUND_EN selects rounding over truncation.
module lcd_in_scaler #(
   parameter int IN_H   = 800,
   parameter int IN_V   = 480,
   parameter int OUT_H  = 400,
   parameter int OUT_V  = 240,
   parameter int VS_POL = 1
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        lcd_de_i,
   input  logic        lcd_vs_i,
   input  logic [23:0] lcd_rgb_i,
   output logic        fifo_clr,
   output logic        wr_req,
   output logic [15:0] wr_data,
   output logic [10:0] out_x,
   output logic [10:0] out_y,
   output logic        frame_done,
   output logic        line_short
);

   localparam logic [11:0] IN_H_W  = 12'(IN_H);
   localparam logic [11:0] IN_V_W  = 12'(IN_V);
   localparam logic [11:0] OUT_H_W = 12'(OUT_H);
   localparam logic [11:0] OUT_V_W = 12'(OUT_V);
   localparam logic [10:0] OUT_H_X = 11'(OUT_H);
   localparam logic [10:0] OUT_V_X = 11'(OUT_V);
   localparam logic        VS_ACT  = (VS_POL != 0);

   // stage 0 and one cycle of history
   logic        de_r, vs_r, de_q, vs_q;
   logic [23:0] rgb_r;

   // frame / line state
   logic        armed;
   logic        line_kept;
   logic [11:0] vacc, hacc;
   logic [10:0] x_cnt, y_cnt;

   // decisions for the pixel held in stage 0
   logic        vs_act, vs_act_q, frame_start, line_start, line_end, active;
   logic [11:0] vsum, hsum, hacc_cur;
   logic [10:0] x_cur;
   logic        keep_line, line_keep_now, keep_px, pix_wr;
   logic [4:0]  r5, b5;
   logic [5:0]  g6;

   // Capture raw LCD inputs and keep the previous DE/VS for edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         de_r  <= 1'b0;
         vs_r  <= 1'b0;
         de_q  <= 1'b0;
         vs_q  <= 1'b0;
         rgb_r <= 24'd0;
      end else begin
         de_r  <= lcd_de_i;
         vs_r  <= lcd_vs_i;
         de_q  <= de_r;
         vs_q  <= vs_r;
         rgb_r <= lcd_rgb_i;
      end
   end

   // Edge detection plus vertical and horizontal DDA decisions; a line-start pixel uses fresh hacc/x
   always_comb begin
      vs_act        = (vs_r == VS_ACT);
      vs_act_q      = (vs_q == VS_ACT);
      frame_start   = vs_act & ~vs_act_q;
      line_start    = de_r & ~de_q;
      line_end      = ~de_r & de_q;
      active        = armed & ~vs_act;
      vsum          = vacc + OUT_V_W;
      keep_line     = (vsum >= IN_V_W) && (y_cnt < OUT_V_X);
      line_keep_now = line_start ? keep_line : line_kept;
      hacc_cur      = line_start ? 12'd0 : hacc;
      x_cur         = line_start ? 11'd0 : x_cnt;
      hsum          = hacc_cur + OUT_H_W;
      keep_px       = (hsum >= IN_H_W) && (x_cur < OUT_H_X);
      pix_wr        = active & de_r & line_keep_now & keep_px;
   end

`ifdef LCD_SCALE_ROUND_EN
   logic [8:0] r_sum, g_sum, b_sum;

   // Round to nearest; a carry out of the 8-bit channel saturates to full scale
   always_comb begin
      r_sum = {1'b0, rgb_r[23:16]} + 9'd4;
      g_sum = {1'b0, rgb_r[15:8]}  + 9'd2;
      b_sum = {1'b0, rgb_r[7:0]}   + 9'd4;
      r5    = r_sum[8] ? 5'd31 : r_sum[7:3];
      g6    = g_sum[8] ? 6'd63 : g_sum[7:2];
      b5    = b_sum[8] ? 5'd31 : b_sum[7:3];
   end
`else
   logic [7:0] lsb_unused;

   // Truncate each channel to its MSBs; the dropped LSBs are intentionally unused
   always_comb begin
      r5         = rgb_r[23:19];
      g6         = rgb_r[15:10];
      b5         = rgb_r[7:3];
      lsb_unused = {rgb_r[18:16], rgb_r[9:8], rgb_r[2:0]};
   end
`endif

   // Frame/line sequencing, accumulators and registered FIFO-side outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         armed      <= 1'b0;
         line_kept  <= 1'b0;
         vacc       <= 12'd0;
         hacc       <= 12'd0;
         x_cnt      <= 11'd0;
         y_cnt      <= 11'd0;
         fifo_clr   <= 1'b0;
         wr_req     <= 1'b0;
         wr_data    <= 16'd0;
         out_x      <= 11'd0;
         out_y      <= 11'd0;
         frame_done <= 1'b0;
         line_short <= 1'b0;
      end else begin
         fifo_clr   <= 1'b0;
         wr_req     <= 1'b0;
         frame_done <= 1'b0;
         if (frame_start) begin
            // frame start wins over any coincident pixel and aborts a line in flight
            fifo_clr   <= 1'b1;
            armed      <= 1'b1;
            line_kept  <= 1'b0;
            vacc       <= 12'd0;
            hacc       <= 12'd0;
            x_cnt      <= 11'd0;
            y_cnt      <= 11'd0;
            out_y      <= 11'd0;
            line_short <= 1'b0;
         end else if (active) begin
            if (line_start) begin
               vacc      <= keep_line ? (vsum - IN_V_W) : vsum;
               line_kept <= keep_line;
            end
            if (de_r && line_keep_now) begin
               hacc  <= keep_px ? (hsum - IN_H_W) : hsum;
               x_cnt <= x_cur + {10'd0, keep_px};
            end
            if (pix_wr) begin
               wr_req     <= 1'b1;
               wr_data    <= {r5, g6, b5};
               out_x      <= x_cur;
               frame_done <= (x_cur == OUT_H_X - 11'd1) && (y_cnt == OUT_V_X - 11'd1);
            end
            if (line_end && line_kept) begin
               line_kept <= 1'b0;
               y_cnt     <= y_cnt + 11'd1;
               // out_y stays on the last line index once the frame is full
               if (y_cnt + 11'd1 < OUT_V_X)
                  out_y <= y_cnt + 11'd1;
               if (x_cnt < OUT_H_X)
                  line_short <= 1'b1;
            end
         end
      end
   end

endmodule
